// File: rtl/chunked_borrow_subtractor_pkg.sv
// Shared definitions for the chunked borrow subtractor: FSM encoding, default
// widths and the chunk-count / index-width derivations.
package chunked_borrow_subtractor_pkg;

  localparam int N_W_DEFAULT = 128;
  localparam int B_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int num_chunks(input int n_w, input int b_w);
    return n_w / b_w;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/chunk_borrow_sub.sv
// Combinational B_W-bit subtract with borrow: {bout, d} = a - b - bin,
// evaluated as a zero-extended (B_W+1)-bit subtraction.
module chunk_borrow_sub #(
  parameter int B_W = 32
) (
  input  logic [B_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic           bin,
  output logic [B_W-1:0] d,
  output logic           bout
);

  logic [B_W:0] res;

  // The MSB of the widened result goes to 1 exactly when a < b + bin.
  always_comb begin
    res = {1'b0, a} - {1'b0, b} - {{B_W{1'b0}}, bin};
  end

  assign d    = res[B_W-1:0];
  assign bout = res[B_W];

endmodule

// File: rtl/chunked_borrow_subtractor.sv
// Multi-cycle wide unsigned subtractor: one B_W-bit chunk per cycle, LSB first,
// with a registered borrow and valid/ready handshakes on both sides.
module chunked_borrow_subtractor
  import chunked_borrow_subtractor_pkg::*;
#(
  parameter int N_W = N_W_DEFAULT,
  parameter int B_W = B_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] a,
  input  logic [N_W-1:0] b,
  input  logic           bin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_W-1:0] diff,
  output logic           bout,
  output logic           zero
);

  localparam int NB    = num_chunks(N_W, B_W);
  localparam int IDX_W = idx_width(NB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

  state_e           state_q, state_d;
  logic [N_W-1:0]   a_q, a_d;
  logic [N_W-1:0]   b_q, b_d;
  logic [N_W-1:0]   diff_q, diff_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             zero_acc_q, zero_acc_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  logic [B_W-1:0]   a_slice, b_slice, chunk_d;
  logic             chunk_bout;

  assign a_slice = a_q[idx_q*B_W +: B_W];
  assign b_slice = b_q[idx_q*B_W +: B_W];

  chunk_borrow_sub #(
    .B_W (B_W)
  ) u_chunk_sub (
    .a    (a_slice),
    .b    (b_slice),
    .bin  (borrow_q),
    .d    (chunk_d),
    .bout (chunk_bout)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    diff_d     = diff_q;
    idx_d      = idx_q;
    borrow_d   = borrow_q;
    zero_acc_d = zero_acc_q;
    bout_d     = bout_q;
    zero_d     = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          borrow_d   = bin;
          idx_d      = '0;
          zero_acc_d = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        diff_d[idx_q*B_W +: B_W] = chunk_d;
        borrow_d   = chunk_bout;
        zero_acc_d = zero_acc_q & (chunk_d == '0);
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          // Publish the flags together with the last chunk so all three
          // outputs become valid on the same edge.
          bout_d  = chunk_bout;
          zero_d  = zero_acc_d;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the operand registers are reset too, not just the control state, so
  // a mid-operation reset leaves no stale operand or partial result behind.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      diff_q     <= '0;
      idx_q      <= '0;
      borrow_q   <= 1'b0;
      zero_acc_q <= 1'b0;
      bout_q     <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      diff_q     <= diff_d;
      idx_q      <= idx_d;
      borrow_q   <= borrow_d;
      zero_acc_q <= zero_acc_d;
      bout_q     <= bout_d;
      zero_q     <= zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;

endmodule
